conv_layer_scheduler: RTL and testbench
=======================================

// Module: conv_layer_scheduler
// PURPOSE
//  Sequences a chain of BRAM-backed conv engines (grouped conv, etc.) through one inference frame.
//  Per enabled layer, in index order: soft-reset the engine, pulse its start, then wait for done or timeout.
//  Engines latch done until reset, so the scheduler clears each engine before starting it.
//  Sits between the frame-level controller (run handshake) and the per-layer start/done pins.
// PARAMETERS
//  NUM_LAYERS      4       number of engines sequenced; index 0 runs first
//  TIMEOUT_CYCLES  262143  max WAIT cycles per layer before error (>=2)
//  LAYER_W         $clog2(NUM_LAYERS) (min 1)        layer index width
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)          cycle counter width
// PORTS
//  clk          in   1           clock; single clock domain
//  reset        in   1           synchronous, active-high
//  run_valid    in   1           frame run request
//  run_ready    out  1           high in IDLE or ERROR; accept = run_valid & run_ready
//  layer_mask   in   NUM_LAYERS  enabled layers; latched on accept
//  abort        in   1           cancel the frame in progress
//  layer_rst    out  NUM_LAYERS  one-cycle engine soft-reset pulses, one-hot or zero
//  layer_start  out  NUM_LAYERS  one-cycle engine start pulses, one-hot or zero
//  layer_done   in   NUM_LAYERS  engine done levels; only the current layer's bit is sampled
//  busy         out  1           high in any state except IDLE/ERROR
//  frame_done   out  1           one-cycle pulse when all enabled layers finish
//  error        out  1           sticky timeout flag; cleared on next accept
//  err_layer    out  LAYER_W     layer index that timed out
//  cur_layer    out  LAYER_W     layer index being processed
//  last_cycles  out  CNT_W       WAIT cycles of the most recently completed layer
// BEHAVIOUR
//  Reset: state=IDLE. run_ready=1. All other outputs 0, including the latched mask and counters.
//  States: IDLE, CLEAR, ISSUE, WAIT, NEXT, FINISH, ERROR.
//  IDLE/ERROR on accept:
//   - latch mask, error<=0, ptr<=lowest enabled index.
//   - mask==0 -> FINISH, else -> CLEAR.
//  CLEAR: layer_rst[ptr]=1 for exactly this cycle -> ISSUE.
//  ISSUE: layer_start[ptr]=1 for exactly this cycle; cnt<=0 -> WAIT.
//  Latency: accept at cycle T -> rst at T+1, start at T+2, first WAIT cycle at T+3.
//  WAIT:
//   - cnt increments each cycle; first WAIT cycle has cnt=1.
//   - layer_done[ptr]=1 -> last_cycles<=cnt (count includes the done cycle) -> NEXT.
//   - Else cnt==TIMEOUT_CYCLES -> error<=1, err_layer<=ptr, layer_rst[ptr] pulsed -> ERROR.
//   - done and timeout in the same cycle: done wins.
//  NEXT: ptr<=next enabled index above ptr -> CLEAR; if none -> FINISH. Takes one cycle.
//  FINISH: frame_done=1 for one cycle -> IDLE.
//  abort in CLEAR/ISSUE/WAIT/NEXT:
//   - layer_rst[ptr] pulsed next cycle -> IDLE.
//   - no frame_done; error unchanged.
//   - abort wins over same-cycle done or timeout.
//  abort in IDLE/ERROR/FINISH is ignored; FINISH completes normally.
//  run_valid while busy: ignored, request not queued. layer_done bits other than ptr are ignored.
//  layer_mask changes after accept have no effect on the frame in progress.
//  reset asserted mid-frame: reset values at the next edge; no start pulses are emitted.
//  cur_layer = ptr, a registered output.
//  cnt never exceeds TIMEOUT_CYCLES, so CNT_W needs no saturation logic.
// STRUCTURE
//  sched_pkg: state enum sched_state_t; functions clog2_min1() and next_enabled(mask, ptr).
//  Sub-module layer_timer: cnt with clear, enable and timeout compare; outputs cnt and expired.
//  Everything else is a single FSM in conv_layer_scheduler; all outputs are registered.
// TESTING
//  1. NUM_LAYERS=4, mask=1111, stubs assert done at WAIT cycle 10/20/5/7:
//     - rst then start pulses for layers 0,1,2,3 in order.
//     - last_cycles=10,20,5,7; exactly one frame_done pulse; run_ready=1 afterwards.
//  2. mask=0101 -> only layers 0 and 2 get rst/start; no pulses on bits 1 and 3; frame_done once.
//  3. TIMEOUT_CYCLES=50, layer 1 never asserts done:
//     - at WAIT cnt=50: error=1, err_layer=1, layer_rst[1] pulse, no frame_done.
//     - next accepted run clears error.
//  4. abort during layer 2 WAIT:
//     - IDLE on the next cycle with a layer_rst[2] pulse.
//     - error=0, no frame_done, layer 3 never started.
//  5. layer 0 asserts done at cnt=50 with TIMEOUT_CYCLES=50 -> treated as success, last_cycles=50.
//     reset asserted mid-WAIT -> all outputs at reset values after one edge.
//  6. mask=0000 -> frame_done one cycle after accept, no starts.
//     run_valid held high while busy -> exactly one frame runs until IDLE.

Source files
------------

// File: rtl/sched_pkg.sv
// sched_pkg: state encoding and index helpers shared by the conv layer scheduler
package sched_pkg;
  localparam int MAX_LAYERS = 32;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_NEXT, S_FINISH, S_ERROR} sched_state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  // lowest set bit of mask strictly above ptr, or -1 when there is none
  function automatic int next_enabled(input logic [MAX_LAYERS-1:0] mask, input int ptr);
    next_enabled = -1;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) if (mask[i] && i > ptr) next_enabled = i;
  endfunction
endpackage

// File: rtl/layer_timer.sv
// layer_timer: per-layer WAIT cycle counter with clear, enable and timeout compare
//   i_clr      zero the counter
//   i_en       advance the counter one step
//   o_cnt      count of the current WAIT cycle (1 on the first WAIT cycle)
//   o_expired  o_cnt has reached TIMEOUT_CYCLES
module layer_timer #(
  parameter int TIMEOUT_CYCLES = 262143,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_expired
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_cnt;
  end
  assign o_cnt = r_cnt + CNT_W'(1);
  assign o_expired = o_cnt == CNT_W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: runs each enabled conv engine in index order (reset, start, wait for done or timeout)
//   run_valid/run_ready  frame request handshake; layer_mask latched on accept
//   abort                cancels the frame in progress
//   layer_rst/start      one-hot single-cycle pulses to the current engine
//   layer_done           engine done levels, only the current bit is looked at
//   busy/frame_done      frame activity and completion pulse
//   error/err_layer      sticky timeout flag and the layer that timed out
//   cur_layer            layer being processed
//   last_cycles          WAIT cycles taken by the most recently completed layer
module conv_layer_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int TIMEOUT_CYCLES = 262143,
  parameter int LAYER_W = clog2_min1(NUM_LAYERS),
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_valid,
  output logic                  run_ready,
  input  logic [NUM_LAYERS-1:0] layer_mask,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] layer_rst,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error,
  output logic [LAYER_W-1:0]    err_layer,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic [CNT_W-1:0]      last_cycles
);
  sched_state_t r_state;
  logic [NUM_LAYERS-1:0] r_mask, r_rst, r_start;
  logic [LAYER_W-1:0] r_ptr, r_err_layer;
  logic [CNT_W-1:0] r_last, w_cnt;
  logic r_ready, r_busy, r_frame_done, r_error, w_expired, w_abort;
  logic [NUM_LAYERS-1:0] w_oh;
  int w_first, w_next;
  assign w_first = next_enabled(MAX_LAYERS'(layer_mask), -1);
  assign w_next = next_enabled(MAX_LAYERS'(r_mask), int'(r_ptr));
  assign w_oh = NUM_LAYERS'(1) << r_ptr;
  assign w_abort = abort && (r_state inside {S_CLEAR, S_ISSUE, S_WAIT, S_NEXT});
  layer_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .i_clr(r_state == S_ISSUE), .i_en(r_state == S_WAIT),
    .o_cnt(w_cnt), .o_expired(w_expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask <= '0;
      r_rst <= '0;
      r_start <= '0;
      r_ptr <= '0;
      r_err_layer <= '0;
      r_last <= '0;
      r_ready <= 1'b1;
      r_busy <= 1'b0;
      r_frame_done <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_rst <= '0;
      r_start <= '0;
      r_frame_done <= 1'b0;
      if (w_abort) begin
        r_rst <= w_oh;
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_ERROR: if (run_valid) begin
            r_mask <= layer_mask;
            r_error <= 1'b0;
            r_ready <= 1'b0;
            r_busy <= 1'b1;
            r_ptr <= (layer_mask == '0) ? '0 : LAYER_W'(w_first);
            if (layer_mask == '0) begin
              r_frame_done <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_rst <= NUM_LAYERS'(1) << w_first;
              r_state <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            r_start <= w_oh;
            r_state <= S_ISSUE;
          end
          S_ISSUE: r_state <= S_WAIT;
          S_WAIT: if (layer_done[r_ptr]) begin
            r_last <= w_cnt;
            r_state <= S_NEXT;
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_err_layer <= r_ptr;
            r_rst <= w_oh;
            r_ready <= 1'b1;
            r_busy <= 1'b0;
            r_state <= S_ERROR;
          end
          S_NEXT: if (w_next < 0) begin
            r_frame_done <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_ptr <= LAYER_W'(w_next);
            r_rst <= NUM_LAYERS'(1) << w_next;
            r_state <= S_CLEAR;
          end
          S_FINISH: begin
            r_ready <= 1'b1;
            r_busy <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
  assign run_ready = r_ready;
  assign layer_rst = r_rst;
  assign layer_start = r_start;
  assign busy = r_busy;
  assign frame_done = r_frame_done;
  assign error = r_error;
  assign err_layer = r_err_layer;
  assign cur_layer = r_ptr;
  assign last_cycles = r_last;
endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb_conv_layer_scheduler: scoreboard bench with engine stubs that raise done after a programmed WAIT cycle
module tb_conv_layer_scheduler;
  logic clk = 1'b0, reset = 1'b1, run_valid = 1'b0, abort = 1'b0;
  logic [3:0] layer_mask = '0, layer_rst, layer_start, layer_done;
  logic run_ready, busy, frame_done, error;
  logic [1:0] err_layer, cur_layer;
  logic [5:0] last_cycles;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int dly[4] = '{0, 0, 0, 0};
  int k[4] = '{0, 0, 0, 0};
  logic act[4] = '{0, 0, 0, 0};
  typedef struct {
    logic [3:0] rst, st;
    logic fd, er;
    logic [1:0] el;
    logic [5:0] lc;
    int c;
  } exp_t;
  exp_t sb[$];
  conv_layer_scheduler #(.NUM_LAYERS(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .run_valid(run_valid), .run_ready(run_ready), .layer_mask(layer_mask),
    .abort(abort), .layer_rst(layer_rst), .layer_start(layer_start), .layer_done(layer_done),
    .busy(busy), .frame_done(frame_done), .error(error), .err_layer(err_layer),
    .cur_layer(cur_layer), .last_cycles(last_cycles)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (layer_rst[i]) begin
        act[i] <= 1'b0;
        k[i] <= 0;
      end else if (layer_start[i]) begin
        act[i] <= 1'b1;
        k[i] <= 1;
      end else if (act[i]) k[i] <= k[i] + 1;
  always_comb
    for (int i = 0; i < 4; i++) layer_done[i] = act[i] && dly[i] != 0 && k[i] >= dly[i];
  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask
  task automatic push(input logic [3:0] r, input logic [3:0] s, input logic fd, input logic er,
                      input logic [1:0] el, input logic [5:0] lc, input int c);
    exp_t e;
    e.rst = r; e.st = s; e.fd = fd; e.er = er; e.el = el; e.lc = lc; e.c = c;
    sb.push_back(e);
  endtask
  task automatic go(input logic [3:0] m);
    run_valid = 1'b1;
    layer_mask = m;
    @(negedge clk);
    run_valid = 1'b0;
    layer_mask = ~m;
  endtask
  task automatic wait_ready(input int lim);
    int n = 0;
    while (!run_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(run_ready), 1);
  endtask
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int t;
    exp_t e;
    fork
      forever begin
        @(negedge clk);
        if (layer_rst != '0 || layer_start != '0 || frame_done) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: rst=%b st=%b fd=%b cyc=%0d", layer_rst, layer_start, frame_done, cyc);
          end else begin
            e = sb.pop_front();
            if (layer_rst != e.rst || layer_start != e.st || frame_done != e.fd || error != e.er ||
                err_layer != e.el || last_cycles != e.lc || cyc != e.c) begin
              n_fail++;
              $display("FAIL event: got rst=%b st=%b fd=%b err=%b el=%0d lc=%0d cyc=%0d, want rst=%b st=%b fd=%b err=%b el=%0d lc=%0d cyc=%0d",
                       layer_rst, layer_start, frame_done, error, err_layer, last_cycles, cyc,
                       e.rst, e.st, e.fd, e.er, e.el, e.lc, e.c);
            end
          end
        end
      end
      begin
        idle_cycles(3);
        chk("rst_ready", int'(run_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({layer_rst, layer_start, frame_done, error}), 0);
        chk("rst_regs", int'({err_layer, cur_layer, last_cycles}), 0);
        reset = 1'b0;
        idle_cycles(1);
        dly = '{10, 20, 5, 7};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 0, 0, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 0, 0, t + 2);
        push(4'b0010, 4'b0000, 0, 0, 0, 10, t + 14);
        push(4'b0000, 4'b0010, 0, 0, 0, 10, t + 15);
        push(4'b0100, 4'b0000, 0, 0, 0, 20, t + 37);
        push(4'b0000, 4'b0100, 0, 0, 0, 20, t + 38);
        push(4'b1000, 4'b0000, 0, 0, 0, 5, t + 45);
        push(4'b0000, 4'b1000, 0, 0, 0, 5, t + 46);
        push(4'b0000, 4'b0000, 1, 0, 0, 7, t + 55);
        go(4'b1111);
        chk("t1_busy", int'(busy), 1);
        wait_ready(100);
        chk("t1_ready_cyc", cyc, t + 56);
        chk("t1_last", int'(last_cycles), 7);
        chk("t1_cur", int'(cur_layer), 3);
        dly = '{3, 1, 4, 1};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 0, 7, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 0, 7, t + 2);
        push(4'b0100, 4'b0000, 0, 0, 0, 3, t + 7);
        push(4'b0000, 4'b0100, 0, 0, 0, 3, t + 8);
        push(4'b0000, 4'b0000, 1, 0, 0, 4, t + 14);
        go(4'b0101);
        wait_ready(100);
        chk("t2_ready_cyc", cyc, t + 15);
        dly = '{2, 0, 1, 1};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 0, 4, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 0, 4, t + 2);
        push(4'b0010, 4'b0000, 0, 0, 0, 2, t + 6);
        push(4'b0000, 4'b0010, 0, 0, 0, 2, t + 7);
        push(4'b0010, 4'b0000, 0, 1, 1, 2, t + 58);
        go(4'b0011);
        wait_ready(100);
        chk("t3_err_cyc", cyc, t + 58);
        chk("t3_error", int'(error), 1);
        chk("t3_err_layer", int'(err_layer), 1);
        chk("t3_busy", int'(busy), 0);
        idle_cycles(3);
        chk("t3_sticky", int'(error), 1);
        dly = '{1, 1, 0, 1};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 1, 2, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 1, 2, t + 2);
        push(4'b0010, 4'b0000, 0, 0, 1, 1, t + 5);
        push(4'b0000, 4'b0010, 0, 0, 1, 1, t + 6);
        push(4'b0100, 4'b0000, 0, 0, 1, 1, t + 9);
        push(4'b0000, 4'b0100, 0, 0, 1, 1, t + 10);
        push(4'b0100, 4'b0000, 0, 0, 1, 1, t + 16);
        go(4'b1111);
        chk("t4_err_clear", int'(error), 0);
        while (cyc < t + 15) @(negedge clk);
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        chk("t4_ready", int'(run_ready), 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_cur", int'(cur_layer), 2);
        idle_cycles(20);
        chk("t4_error", int'(error), 0);
        abort = 1'b1;
        idle_cycles(2);
        abort = 1'b0;
        chk("idle_abort_ready", int'(run_ready), 1);
        dly = '{50, 0, 0, 0};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 1, 1, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 1, 1, t + 2);
        push(4'b0000, 4'b0000, 1, 0, 1, 50, t + 54);
        go(4'b0001);
        wait_ready(100);
        chk("t5_ready_cyc", cyc, t + 55);
        chk("t5_error", int'(error), 0);
        chk("t5_last", int'(last_cycles), 50);
        dly = '{0, 0, 0, 0};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 1, 50, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 1, 50, t + 2);
        go(4'b1111);
        while (cyc < t + 10) @(negedge clk);
        reset = 1'b1;
        idle_cycles(1);
        chk("mid_rst_ready", int'(run_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_outs", int'({layer_rst, layer_start, frame_done, error}), 0);
        chk("mid_rst_regs", int'({err_layer, cur_layer, last_cycles}), 0);
        reset = 1'b0;
        idle_cycles(5);
        t = cyc;
        push(4'b0000, 4'b0000, 1, 0, 0, 0, t + 1);
        go(4'b0000);
        chk("t6_fd_busy", int'(busy), 1);
        chk("t6_fd_ready", int'(run_ready), 0);
        idle_cycles(1);
        chk("t6_ready", int'(run_ready), 1);
        chk("t6_ready_cyc", cyc, t + 2);
        dly = '{5, 0, 0, 0};
        t = cyc;
        push(4'b0001, 4'b0000, 0, 0, 0, 0, t + 1);
        push(4'b0000, 4'b0001, 0, 0, 0, 0, t + 2);
        push(4'b0000, 4'b0000, 1, 0, 0, 5, t + 9);
        run_valid = 1'b1;
        layer_mask = 4'b0001;
        idle_cycles(1);
        wait_ready(50);
        run_valid = 1'b0;
        chk("t6_hold_cyc", cyc, t + 10);
        idle_cycles(8);
        chk("sb_empty", sb.size(), 0);
      end
      begin
        repeat (20000) @(posedge clk);
        n_chk++;
        n_fail++;
        $display("FAIL global_timeout: cyc=%0d, limit 20000", cyc);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
